// File: rtl/fft_out_reader_if.sv
// rtl/fft_out_reader_if.sv - capture-side and result-stream signals of the FFT output reader
interface fft_out_reader_if #(
  parameter int W = 16
);
  logic              fft_ready;
  logic              capture;
  logic [16*W-1:0]   fft_bins;
  logic              m_valid;
  logic              m_ready;
  logic [W-1:0]      m_real;
  logic [W-1:0]      m_imag;
  logic [2:0]        m_index;
  logic              m_last;
  logic              busy;
  logic              overrun;
  logic              clr_ovr;
  logic [7:0]        frame_cnt;

  modport master (
    input  fft_ready, capture, fft_bins, m_ready, clr_ovr,
    output m_valid, m_real, m_imag, m_index, m_last, busy, overrun, frame_cnt
  );

  modport slave (
    output fft_ready, capture, fft_bins, m_ready, clr_ovr,
    input  m_valid, m_real, m_imag, m_index, m_last, busy, overrun, frame_cnt
  );
endinterface

// File: rtl/fft_out_reader.sv
// rtl/fft_out_reader.sv - latches eight FFT bins and streams them in order 0..7
// Define SMAG_CONV_EN to convert sign-magnitude words to two's complement at capture.
module fft_out_reader #(
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_out_reader_if.master   bus
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t         state_q, state_d;
  logic           ready_q, ready_d;
  logic [W-1:0]   buf_q [16];
  logic [W-1:0]   buf_d [16];
  logic [2:0]     idx_q, idx_d;
  logic           m_valid_q, m_valid_d;
  logic           busy_q, busy_d;
  logic           overrun_q, overrun_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic           ev;
  logic           beat;
  logic           load;
  logic           ovr_set;

  function automatic logic [W-1:0] conv_word(input logic [W-1:0] w);
`ifdef SMAG_CONV_EN
    conv_word = w[W-1] ? ({W{1'b0}} - {1'b0, w[W-2:0]}) : w;
`else
    conv_word = w;
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    ready_d     = bus.fft_ready;
    idx_d       = idx_q;
    m_valid_d   = m_valid_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    load        = 1'b0;
    ovr_set     = 1'b0;
    ev          = (bus.fft_ready & ~ready_q) | bus.capture;
    beat        = m_valid_q & bus.m_ready;

    case (state_q)
      IDLE: begin
        if (ev) begin
          load      = 1'b1;
          idx_d     = 3'd0;
          m_valid_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (beat && idx_q == 3'd7) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          // A capture coinciding with the final beat chains frames without a bubble.
          if (ev) begin
            load  = 1'b1;
            idx_d = 3'd0;
          end else begin
            m_valid_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          if (beat) idx_d = idx_q + 3'd1;
          if (ev)   ovr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    overrun_d = ovr_set | (overrun_q & ~bus.clr_ovr);

    for (int k = 0; k < 16; k++) begin
      buf_d[k] = load ? conv_word(bus.fft_bins[k*W +: W]) : buf_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      idx_q       <= 3'd0;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      for (int k = 0; k < 16; k++) buf_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      idx_q       <= idx_d;
      m_valid_q   <= m_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      for (int k = 0; k < 16; k++) buf_q[k] <= buf_d[k];
    end
  end

  // Buffer word 2k holds bin k real, 2k+1 holds bin k imag.
  assign bus.m_real    = buf_q[{idx_q, 1'b0}];
  assign bus.m_imag    = buf_q[{idx_q, 1'b1}];
  assign bus.m_index   = idx_q;
  assign bus.m_last    = m_valid_q & (idx_q == 3'd7);
  assign bus.m_valid   = m_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_out_reader.sv
// tb/tb_fft_out_reader.sv - directed and random checks of fft_out_reader against a frame-level model
module tb_fft_out_reader;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  fft_out_reader_if #(.W(16)) bus ();

  fft_out_reader #(.W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: currently held frame, position of the presented bin, counters.
  logic [15:0] mdl_re [8];
  logic [15:0] mdl_im [8];
  bit          mdl_valid;
  int          mdl_pos;
  int          mdl_cnt;
  bit          mdl_ovr;
  bit          mdl_prev_ready;

  function automatic logic [15:0] conv(input logic [15:0] w);
`ifdef SMAG_CONV_EN
    if (w[15]) return 16'(-int'(w[14:0]));
    return w;
`else
    return w;
`endif
  endfunction

  task automatic mdl_clear();
    for (int k = 0; k < 8; k++) begin
      mdl_re[k] = 16'h0;
      mdl_im[k] = 16'h0;
    end
    mdl_valid      = 1'b0;
    mdl_pos        = 0;
    mdl_cnt        = 0;
    mdl_ovr        = 1'b0;
    mdl_prev_ready = 1'b0;
  endtask

  task automatic mdl_take_frame();
    for (int k = 0; k < 8; k++) begin
      mdl_re[k] = bus.fft_bins[32*k +: 16];
      mdl_im[k] = bus.fft_bins[32*k+16 +: 16];
    end
    mdl_pos   = 0;
    mdl_valid = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_clear();
    end else begin
      bit event_now;
      bit accepted;
      bit lost;
      event_now = (bus.fft_ready && !mdl_prev_ready) || bus.capture;
      accepted  = mdl_valid && bus.m_ready;
      lost      = 1'b0;
      if (!mdl_valid) begin
        if (event_now) mdl_take_frame();
      end else if (accepted && mdl_pos == 7) begin
        mdl_cnt = (mdl_cnt + 1) % 256;
        if (event_now) mdl_take_frame();
        else mdl_valid = 1'b0;
      end else begin
        if (accepted) mdl_pos = mdl_pos + 1;
        lost = event_now;
      end
      if (lost) mdl_ovr = 1'b1;
      else if (bus.clr_ovr) mdl_ovr = 1'b0;
      mdl_prev_ready = bus.fft_ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("m_valid",   32'(bus.m_valid),   32'(mdl_valid));
    chk("m_real",    32'(bus.m_real),    32'(conv(mdl_re[mdl_pos])));
    chk("m_imag",    32'(bus.m_imag),    32'(conv(mdl_im[mdl_pos])));
    chk("m_index",   32'(bus.m_index),   32'(mdl_pos));
    chk("m_last",    32'(bus.m_last),    32'(mdl_valid && mdl_pos == 7));
    chk("busy",      32'(bus.busy),      32'(mdl_valid));
    chk("overrun",   32'(bus.overrun),   32'(mdl_ovr));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(mdl_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic set_bin(input int k, input logic [15:0] re, input logic [15:0] im);
    bus.fft_bins[32*k +: 16]    = re;
    bus.fft_bins[32*k+16 +: 16] = im;
  endtask

  task automatic random_bins();
    for (int k = 0; k < 8; k++) set_bin(k, 16'($urandom), 16'($urandom));
  endtask

  task automatic drain();
    int n;
    bus.m_ready = 1'b1;
    bus.capture = 1'b0;
    bus.clr_ovr = 1'b0;
    n = 0;
    while (mdl_valid && n < 20) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(mdl_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_neg5;
    logic [15:0] exp_negz;
    logic [15:0] new_re0;
    vectors     = 0;
    miscompares = 0;
    mdl_clear();
    rst_n         = 1'b0;
    bus.fft_ready = 1'b0;
    bus.capture   = 1'b0;
    bus.fft_bins  = '0;
    bus.m_ready   = 1'b0;
    bus.clr_ovr   = 1'b0;
    repeat (3) @(negedge clk);
    check_all();
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_cnt",   32'(bus.frame_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Known frame at full rate.
    for (int k = 0; k < 8; k++) set_bin(k, 16'(k + 1), 16'(16'h10 + k));
    bus.fft_ready = 1'b1;
    bus.m_ready   = 1'b1;
    step();
    chk("t1_valid0", 32'(bus.m_valid), 32'd1);
    chk("t1_idx0",   32'(bus.m_index), 32'd0);
    chk("t1_real0",  32'(bus.m_real),  32'd1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("t1_idx", 32'(bus.m_index), 32'(i));
      chk("t1_imag", 32'(bus.m_imag), 32'(16'h10 + i));
    end
    chk("t1_last", 32'(bus.m_last), 32'd1);
    step();
    chk("t1_done_valid", 32'(bus.m_valid), 32'd0);
    chk("t1_done_busy",  32'(bus.busy), 32'd0);
    chk("t1_cnt",        32'(bus.frame_cnt), 32'd1);
    step();
    chk("t1_hold_once", 32'(bus.m_valid), 32'd0);

    // Same frame with a stalling consumer.
    bus.fft_ready = 1'b0;
    step();
    bus.fft_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.m_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    drain();
    chk("t2_cnt", 32'(bus.frame_cnt), 32'd2);

    // Capture pulse mid-frame is dropped and flagged.
    random_bins();
    bus.capture = 1'b1;
    step();
    bus.capture = 1'b0;
    step();
    step();
    step();
    chk("t3_at3", 32'(bus.m_index), 32'd3);
    random_bins();
    bus.capture = 1'b1;
    step();
    bus.capture = 1'b0;
    chk("t3_ovr_set", 32'(bus.overrun), 32'd1);
    bus.clr_ovr = 1'b1;
    step();
    chk("t3_ovr_clr", 32'(bus.overrun), 32'd0);
    bus.capture = 1'b1;
    step();
    chk("t3_ovr_both", 32'(bus.overrun), 32'd1);
    bus.capture = 1'b0;
    step();
    bus.clr_ovr = 1'b0;
    chk("t3_ovr_clr2", 32'(bus.overrun), 32'd0);
    chk("t3_at7", 32'(bus.m_index), 32'd7);

    // Capture on the final beat chains the next frame.
    random_bins();
    new_re0 = bus.fft_bins[15:0];
    bus.capture = 1'b1;
    step();
    bus.capture = 1'b0;
    chk("t4_valid", 32'(bus.m_valid), 32'd1);
    chk("t4_idx",   32'(bus.m_index), 32'd0);
    chk("t4_real",  32'(bus.m_real),  32'(conv(new_re0)));
    chk("t4_cnt",   32'(bus.frame_cnt), 32'd3);

    // Reset mid-frame at bin 4, released with fft_ready held high.
    repeat (4) step();
    chk("t5_at4", 32'(bus.m_index), 32'd4);
    #2 rst_n = 1'b0;
    #1 check_all();
    chk("t5_rst_valid", 32'(bus.m_valid), 32'd0);
    chk("t5_rst_real",  32'(bus.m_real),  32'd0);
    chk("t5_rst_cnt",   32'(bus.frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t5_recap", 32'(bus.m_valid), 32'd1);
    chk("t5_idx0",  32'(bus.m_index), 32'd0);
    drain();

    // Sign-magnitude words.
`ifdef SMAG_CONV_EN
    exp_neg5 = 16'hFFFB;
    exp_negz = 16'h0000;
`else
    exp_neg5 = 16'h8005;
    exp_negz = 16'h8000;
`endif
    random_bins();
    set_bin(2, 16'h8005, 16'h8000);
    bus.m_ready = 1'b0;
    bus.capture = 1'b1;
    step();
    bus.capture = 1'b0;
    bus.m_ready = 1'b1;
    step();
    step();
    bus.m_ready = 1'b0;
    step();
    chk("t6_real", 32'(bus.m_real), 32'(exp_neg5));
    chk("t6_imag", 32'(bus.m_imag), 32'(exp_negz));
    drain();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      random_bins();
      if ($urandom_range(0, 5) == 0) bus.fft_ready = ~bus.fft_ready;
      bus.capture = ($urandom_range(0, 11) == 0);
      bus.m_ready = ($urandom_range(0, 3) != 0);
      bus.clr_ovr = ($urandom_range(0, 9) == 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_out_reader.md
# fft_out_reader

Result-side reader for the 8-point FFT core. Captures the eight complex bins presented in parallel when the FFT signals completion and streams them out one bin per cycle over a valid/ready handshake, in natural order 0..7. It sits between the FFT output registers and any serial consumer (FIFO, UART framer, DMA), and optionally converts the FFT's sign-magnitude words to two's complement.

## Interface
- W, 16, width of each real/imag word
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- fft_ready  in  1  FFT completion level; its 0->1 transition is a capture event
- capture  in  1  single-cycle pulse; forces a capture event when fft_ready stays high between frames
- fft_bins  in  16*W  bin k real at [2kW+W-1:2kW], imag at [2kW+2W-1:2kW+W], k=0..7
- m_valid  out  1  output bin valid
- m_ready  in  1  consumer accepts bin
- m_real  out  W  real word of current bin
- m_imag  out  W  imag word of current bin
- m_index  out  3  bin index of current word
- m_last  out  1  high with bin 7
- busy  out  1  frame held or streaming
- overrun  out  1  sticky: capture event lost
- clr_ovr  in  1  synchronous clear of overrun
- frame_cnt  out  8  completed frames, wraps 255->0

## Operation
- Capture event ev = (fft_ready & ~ready_q) | capture; ready_q is fft_ready registered.
- States: IDLE, STREAM.
- IDLE: on ev, latch all of fft_bins into 16-word buffer, idx<=0, m_valid<=1, busy<=1, go STREAM. Else outputs hold.
- STREAM: beat = m_valid & m_ready. On beat with idx<7: idx<=idx+1, next bin presented. On beat with idx==7: frame_cnt+1; if ev same cycle reload buffer, idx<=0, stay STREAM (no bubble); else m_valid<=0, busy<=0, go IDLE.
- ev in STREAM without final beat: buffer untouched, event dropped, overrun<=1.
- overrun clears only on clr_ovr or reset; clr_ovr and a new overrun in same cycle -> overrun stays 1.
- m_real/m_imag/m_index/m_last driven from registered buffer and idx; stable while m_valid & ~m_ready.
- m_last = m_valid & (idx==7).
- m_ready ignored while m_valid low.

## Timing
- Reset values: m_valid 0, m_real 0, m_imag 0, m_index 0, m_last 0, busy 0, overrun 0, frame_cnt 0, ready_q 0, state IDLE.
- ev sampled at edge t -> bin 0 valid after edge t (1-cycle latency).
- Full-rate m_ready: 8 beats in 8 consecutive cycles; frame period min 8 cycles with back-to-back ev.
- Reset asserted mid-frame: stream aborted immediately, buffer contents discarded, frame_cnt not incremented.
- After reset release with fft_ready already high: ready_q=0, so first clock produces ev and a capture.
- fft_ready held high: only one capture; further frames need capture pulse.

## Configuration
- SMAG_CONV_EN defined: each word converted at capture, sign-magnitude -> two's complement; 0x8000 (-0) -> 0x0000; e.g. 0x8005 -> 0xFFFB, 0x0005 -> 0x0005.
- SMAG_CONV_EN undefined: words passed raw, bit-exact as latched.
- Timing and latency identical in both builds.

## Test plan
- Reset then fft_ready 0->1 with bin k real=k+1, imag=0x10+k, m_ready=1 -> m_valid 8 cycles, m_index 0..7, m_last only on 7, frame_cnt=1, busy drops next cycle.
- Same frame, m_ready toggled 1,0,0,1,... -> each bin held stable during stalls, no skipped or repeated index.
- capture pulse at cycle of bin 3 beat -> overrun=1, stream continues with original data; clr_ovr -> overrun=0.
- capture pulse on bin 7 beat with new data -> next cycle m_valid=1, m_index=0, new data, frame_cnt incremented once.
- RST_N low at bin 4 -> all outputs zero asynchronously; release with fft_ready=1 -> fresh capture, bin 0 next cycle.
- With SMAG_CONV_EN: bin 2 real 0x8005 -> m_real 0xFFFB; 0x8000 -> 0x0000; without macro -> 0x8005, 0x8000.
